// File: rtl/rnn_bus_pkg.sv
// Shared bus map, field positions and master state
// for the RNN accelerator host-side initiator.
package rnn_bus_pkg;

  typedef enum logic [3:0] {
    START  = 4'd0,
    INPUT  = 4'd1,
    W0     = 4'd2,
    W1     = 4'd3,
    RBIAS  = 4'd4,
    DENSE  = 4'd5,
    DBIAS  = 4'd6,
    STATUS = 4'd7,
    RESULT = 4'd8
  } bus_addr_e;

  localparam int ROW_MSB  = 31;
  localparam int ROW_LSB  = 24;
  localparam int COL_MSB  = 23;
  localparam int COL_LSB  = 16;
  localparam int DATA_MSB = 15;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR,
    S_START,
    S_GAP,
    S_POLL_RD,
    S_POLL_CHK,
    S_RES_RD,
    S_RES_CHK,
    S_OUT
  } mst_state_e;

  function automatic logic [31:0] addr_word(
    input bus_addr_e a
  );
    return {28'd0, a};
  endfunction

endpackage

// File: rtl/rnn_word_pack.sv
// Combinational packing of a parameter command into
// the slave address and write word.
module rnn_word_pack
  import rnn_bus_pkg::*;
(
  input  logic [2:0]  i_tensor,
  input  logic [7:0]  i_row,
  input  logic [7:0]  i_col,
  input  logic [15:0] i_data,
  output logic [31:0] o_addr,
  output logic [31:0] o_wdata,
  output logic        o_legal
);

  always_comb begin
    o_addr  = {29'd0, i_tensor};
    o_wdata = '0;
    o_wdata[DATA_MSB:0] = i_data;
    o_legal = 1'b1;
    case (i_tensor)
      3'(W0), 3'(W1): begin
        o_wdata[ROW_MSB:ROW_LSB] = i_row;
        o_wdata[COL_MSB:COL_LSB] = i_col;
      end
      3'(INPUT), 3'(RBIAS), 3'(DENSE): begin
        o_wdata[COL_MSB:COL_LSB] = i_col;
      end
      3'(DBIAS): begin
        o_wdata[DATA_MSB:0] = i_data;
      end
      default: o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/rnn_host_master.sv
// Host-side bus initiator: streams parameter writes,
// starts the accelerator, polls status, returns result.
module rnn_host_master
  import rnn_bus_pkg::*;
#(
  parameter int POLL_GAP = 4,
  parameter int TIMEOUT  = 1024,
  parameter int CNT_W    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_tensor,
  input  logic [7:0]  cmd_row,
  input  logic [7:0]  cmd_col,
  input  logic [15:0] cmd_data,
  input  logic        cmd_last,
  output logic        bus_write,
  output logic        bus_read,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        busy,
  output logic [1:0]  err
);

  localparam logic [CNT_W-1:0] LP_GAP = CNT_W'(POLL_GAP);
  localparam logic [CNT_W-1:0] LP_TO  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] LP_ONE = CNT_W'(1);

  mst_state_e       r_state;
  logic             r_cmd_ready;
  logic             r_bus_write;
  logic             r_bus_read;
  logic [31:0]      r_bus_addr;
  logic [31:0]      r_bus_wdata;
  logic             r_res_valid;
  logic [15:0]      r_res_data;
  logic             r_busy;
  logic [1:0]       r_err;
  logic             r_last;
  logic [CNT_W-1:0] r_gap;
  logic [CNT_W-1:0] r_to;

  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_legal;
  logic        w_unused;

  assign w_unused = ^bus_rdata[31:16];

  rnn_word_pack u_pack (
    .i_tensor (cmd_tensor),
    .i_row    (cmd_row),
    .i_col    (cmd_col),
    .i_data   (cmd_data),
    .o_addr   (w_addr),
    .o_wdata  (w_wdata),
    .o_legal  (w_legal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b1;
      r_bus_write <= 1'b0;
      r_bus_read  <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_busy      <= 1'b0;
      r_err       <= '0;
      r_last      <= 1'b0;
      r_gap       <= '0;
      r_to        <= '0;
    end else begin
      // strobes are single-cycle unless re-armed below
      r_bus_write <= 1'b0;
      r_bus_read  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            if (w_legal) begin
              r_state     <= S_WR;
              r_bus_write <= 1'b1;
              r_bus_addr  <= w_addr;
              r_bus_wdata <= w_wdata;
              r_last      <= cmd_last;
              r_err       <= 2'b00;
              r_cmd_ready <= 1'b0;
              r_busy      <= 1'b1;
            end else begin
              r_err <= 2'b01;
            end
          end
        end
        S_WR: begin
          if (r_last) begin
            r_state     <= S_START;
            r_bus_write <= 1'b1;
            r_bus_addr  <= addr_word(START);
            r_bus_wdata <= '0;
          end else begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        S_START: begin
          r_to    <= '0;
          r_gap   <= LP_GAP;
          r_state <= S_GAP;
        end
        S_GAP: begin
          r_gap <= r_gap - LP_ONE;
          if (r_gap <= LP_ONE) begin
            r_state    <= S_POLL_RD;
            r_bus_read <= 1'b1;
            r_bus_addr <= addr_word(STATUS);
          end
        end
        S_POLL_RD: begin
          r_to    <= r_to + LP_ONE;
          r_state <= S_POLL_CHK;
        end
        S_POLL_CHK: begin
          if (bus_rdata[0]) begin
            r_state    <= S_RES_RD;
            r_bus_read <= 1'b1;
            r_bus_addr <= addr_word(RESULT);
          end else if (r_to == LP_TO) begin
            r_err[1]    <= 1'b1;
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
          end else begin
            r_gap   <= LP_GAP;
            r_state <= S_GAP;
          end
        end
        S_RES_RD: begin
          r_state <= S_RES_CHK;
        end
        S_RES_CHK: begin
          r_res_data  <= bus_rdata[15:0];
          r_res_valid <= 1'b1;
          r_state     <= S_OUT;
        end
        S_OUT: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign bus_write = r_bus_write;
  assign bus_read  = r_bus_read;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign busy      = r_busy;
  assign err       = r_err;

endmodule

// File: tb/tb_rnn_host_master.sv
// Randomized bench for rnn_host_master with a bus
// slave model and a transaction-level scoreboard.
module tb_rnn_host_master;

  localparam int PG = 2;
  localparam int TO = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_tensor = '0;
  logic [7:0]  cmd_row = '0;
  logic [7:0]  cmd_col = '0;
  logic [15:0] cmd_data = '0;
  logic        cmd_last = 1'b0;
  logic        bus_write;
  logic        bus_read;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_data;
  logic        busy;
  logic [1:0]  err;

  always #5 clk = ~clk;

  rnn_host_master #(
    .POLL_GAP (PG),
    .TIMEOUT  (TO),
    .CNT_W    (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_tensor (cmd_tensor),
    .cmd_row    (cmd_row),
    .cmd_col    (cmd_col),
    .cmd_data   (cmd_data),
    .cmd_last   (cmd_last),
    .bus_write  (bus_write),
    .bus_read   (bus_read),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .busy       (busy),
    .err        (err)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } ev_t;

  ev_t obs_q[$];
  ev_t exp_q[$];

  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          nb = 0;
  int          stat_cnt = 0;
  logic [31:0] res_word = '0;
  logic [1:0]  exp_err = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, obs, exp);
    end
  endtask

  // bus monitor and slave: status busy for nb polls
  always @(negedge clk) begin
    if (bus_write || bus_read) begin
      check("wr_rd_excl",
            {31'd0, bus_write & bus_read}, 0);
      obs_q.push_back('{bus_write, bus_addr,
                        bus_write ? bus_wdata : 32'd0,
                        cyc});
      if (bus_write && bus_addr == 0) stat_cnt = 0;
      if (bus_read) begin
        if (bus_addr == 7) begin
          bus_rdata = ($urandom & 32'hFFFF_FFFE) |
                      {31'd0, stat_cnt >= nb};
          stat_cnt++;
        end else begin
          bus_rdata = res_word;
        end
      end
    end
  end

  function automatic logic [31:0] model_word(
    input logic [2:0]  t,
    input logic [7:0]  r,
    input logic [7:0]  c,
    input logic [15:0] d
  );
    int row = int'(r);
    int col = int'(c);
    int dat = int'(d);
    case (t)
      3'd2, 3'd3: return 32'(row * 16777216 + col * 65536 + dat);
      3'd1, 3'd4, 3'd5: return 32'(col * 65536 + dat);
      default: return 32'(dat);
    endcase
  endfunction

  task automatic check_reset(input string p);
    check({p, "_cmd_ready"}, cmd_ready, 1);
    check({p, "_bus_write"}, bus_write, 0);
    check({p, "_bus_read"}, bus_read, 0);
    check({p, "_bus_addr"}, bus_addr, 0);
    check({p, "_bus_wdata"}, bus_wdata, 0);
    check({p, "_res_valid"}, res_valid, 0);
    check({p, "_res_data"}, res_data, 0);
    check({p, "_busy"}, busy, 0);
    check({p, "_err"}, err, 0);
  endtask

  task automatic send(
    input  logic [2:0]  t,
    input  logic [7:0]  r,
    input  logic [7:0]  c,
    input  logic [15:0] d,
    input  logic        last,
    output int          hs
  );
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check("cmd_ready_wait", cmd_ready, 1);
    cmd_valid  = 1'b1;
    cmd_tensor = t;
    cmd_row    = r;
    cmd_col    = c;
    cmd_data   = d;
    cmd_last   = last;
    hs = cyc;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_last  = 1'b0;
  endtask

  task automatic issue(
    input logic [2:0]  t,
    input logic [7:0]  r,
    input logic [7:0]  c,
    input logic [15:0] d,
    input logic        last
  );
    int hs, np, p0, pl, n;
    bit ok;
    bit legal = (t >= 1 && t <= 6);
    send(t, r, c, d, last, hs);
    if (!legal) begin
      exp_err = 2'b01;
      check("ready_after_illegal", cmd_ready, 1);
      check("err_illegal", err, exp_err);
      return;
    end
    exp_err = 2'b00;
    check("ready_low_wr", cmd_ready, 0);
    check("busy_wr", busy, 1);
    check("err_cleared", err, 0);
    exp_q.push_back('{1'b1, {29'd0, t},
                      model_word(t, r, c, d), hs + 1});
    if (!last) return;
    exp_q.push_back('{1'b1, 32'd0, 32'd0, hs + 2});
    ok = nb < TO;
    np = ok ? nb + 1 : TO;
    p0 = hs + 2 + PG + 1;
    for (int i = 0; i < np; i++)
      exp_q.push_back('{1'b0, 32'd7, 32'd0,
                        p0 + i * (PG + 2)});
    pl = p0 + (np - 1) * (PG + 2);
    n = 0;
    if (ok) begin
      exp_q.push_back('{1'b0, 32'd8, 32'd0, pl + 2});
      while (!res_valid && n < 500) begin
        @(negedge clk);
        n++;
      end
      check("res_valid_cyc", cyc, pl + 4);
      check("res_data", res_data, {16'd0, res_word[15:0]});
      repeat ($urandom_range(0, 4)) @(negedge clk);
      check("res_hold_valid", res_valid, 1);
      check("res_hold_data", res_data, {16'd0, res_word[15:0]});
      check("ready_low_out", cmd_ready, 0);
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      check("res_valid_drop", res_valid, 0);
      check("ready_after_out", cmd_ready, 1);
    end else begin
      exp_err = 2'b10;
      while (busy && n < 500) begin
        @(negedge clk);
        n++;
      end
      check("timeout_cyc", cyc, pl + 2);
      check("err_timeout", err, exp_err);
      check("ready_after_to", cmd_ready, 1);
    end
  endtask

  task automatic sb_flush();
    repeat (3) @(negedge clk);
    check("n_events", obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      check("ev_kind", obs_q[i].wr, exp_q[i].wr);
      check("ev_addr", obs_q[i].addr, exp_q[i].addr);
      check("ev_data", obs_q[i].data, exp_q[i].data);
      check("ev_cyc", obs_q[i].cyc, exp_q[i].cyc);
    end
    check("err_model", err, exp_err);
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int hs, k;
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst");
    rst = 1'b0;

    nb = 0;
    issue(3'd2, 8'd3, 8'd9, 16'h1234, 1'b0);
    issue(3'd5, 8'($urandom), 8'd2, 16'hFFFF, 1'b0);
    issue(3'd6, 8'($urandom), 8'($urandom), 16'h0100, 1'b0);
    sb_flush();

    issue(3'd7, 8'd1, 8'd1, 16'h5555, 1'b0);
    sb_flush();
    issue(3'd0, 8'd0, 8'd0, 16'h0001, 1'b1);
    issue(3'd1, 8'd0, 8'd4, 16'h0042, 1'b0);
    sb_flush();

    nb = 2;
    res_word = 32'hABCD5678;
    issue(3'd1, 8'd0, 8'd0, 16'h7777, 1'b1);
    sb_flush();

    nb = 5;
    issue(3'd4, 8'd0, 8'd1, 16'h0001, 1'b1);
    sb_flush();

    for (int it = 0; it < 25; it++) begin
      k = $urandom_range(1, 4);
      nb = $urandom_range(0, 4);
      res_word = $urandom;
      for (int j = 0; j < k; j++)
        issue(3'($urandom_range(0, 7)), 8'($urandom),
              8'($urandom), 16'($urandom), j == k - 1);
      sb_flush();
    end

    nb = 20;
    send(3'd3, 8'd1, 8'd1, 16'h0001, 1'b1, hs);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset("midrst");
    rst = 1'b0;
    obs_q.delete();
    exp_q.delete();
    exp_err = 2'b00;
    repeat (20) @(negedge clk);
    check("no_strobe_after_rst", obs_q.size(), 0);
    check("idle_after_rst", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
